// File: rtl/kw_scan_if.sv
// Symbol/result handshake bundle for the keyword-scan controller.
// Both channels use the same valid/ready rule: a transfer happens on a rising
// clk edge where valid and ready are both 1; the sender holds valid and its
// payload steady until that edge, and ready may depend on state but never on
// the same-cycle valid.
interface kw_scan_if #(
  parameter int BW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_code;
  logic          out_hit;
  logic [BW-1:0] out_bank;

  // Producer of symbols / consumer of results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_code, out_hit, out_bank
  );

  // The scan controller itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_code, out_hit, out_bank
  );
endinterface

// File: rtl/kw_scan_ctrl.sv
// Keyword-scan controller: NBANK programmable 64-bit keyword banks (8 symbols
// each), one symbol accepted at a time, banks walked one per cycle through a
// single shared 8-way byte comparator, registered result plus a saturating
// hit counter.
module kw_scan_ctrl #(
  parameter int NBANK = 4,
  parameter int BW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [BW-1:0] cfg_addr,
  input  logic [63:0]   cfg_data,
  input  logic          cfg_clr,
  kw_scan_if.slave      bus,
  output logic          busy,
  output logic [15:0]   stat_hits,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam logic [BW-1:0] LAST_BANK = BW'(NBANK - 1);

  state_t          state_q, state_d;
  logic [BW-1:0]   ptr_q, ptr_d;
  logic [7:0]      sym_q, sym_d;
  logic [7:0]      code_q, code_d;
  logic            hit_q, hit_d;
  logic [BW-1:0]   res_bank_q, res_bank_d;
  logic [15:0]     hit_cnt_q, hit_cnt_d;

  logic [63:0]     kw_mem [NBANK];
  logic [NBANK-1:0] valid_q;

  logic [63:0]     cur_bank;
  logic            byte_eq;
  logic            hit_now;
  logic [7:0]      miss_code;

  // Keyword bank storage; clear-then-write ordering lets a simultaneous
  // cfg_we leave its own bank valid while every other bank is cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NBANK; i++) kw_mem[i] <= '0;
      valid_q <= '0;
    end else begin
      if (cfg_clr) valid_q <= '0;
      if (cfg_we) begin
        kw_mem[cfg_addr]  <= cfg_data;
        valid_q[cfg_addr] <= 1'b1;
      end
    end
  end

  // Shared comparator: the latched symbol against all 8 bytes of bank[ptr].
  // Reads the registered bank, so a same-cycle write is not yet visible.
  always_comb begin
    cur_bank = kw_mem[ptr_q];
    byte_eq  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (cur_bank[8*k +: 8] == sym_q) byte_eq = 1'b1;
    end
    hit_now = valid_q[ptr_q] & byte_eq;
  end

  // Code reported when no valid bank holds the symbol.
  always_comb begin
    miss_code = 8'd0;
    if (sym_q == 8'd7)      miss_code = 8'd63;
    else if (sym_q == 8'd9) miss_code = 8'd191;
  end

  // State, scan pointer, symbol, result and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sym_q      <= '0;
      code_q     <= '0;
      hit_q      <= 1'b0;
      res_bank_q <= '0;
      hit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sym_q      <= sym_d;
      code_q     <= code_d;
      hit_q      <= hit_d;
      res_bank_q <= res_bank_d;
      hit_cnt_q  <= hit_cnt_d;
    end
  end

  // Next-state logic: accept in IDLE, walk banks in SCAN, hold the result
  // in RESULT until the consumer takes it.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sym_d      = sym_q;
    code_d     = code_q;
    hit_d      = hit_q;
    res_bank_d = res_bank_q;
    hit_cnt_d  = hit_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sym_d   = bus.in_data;
          ptr_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (hit_now) begin
          hit_d      = 1'b1;
          res_bank_d = ptr_q;
          code_d     = 8'd127;
          state_d    = RESULT;
        end else if (ptr_q == LAST_BANK) begin
          hit_d      = 1'b0;
          res_bank_d = '0;
          code_d     = miss_code;
          state_d    = RESULT;
        end else begin
          ptr_d = ptr_q + BW'(1);
        end
      end
      RESULT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          if (hit_q && (hit_cnt_q != 16'hFFFF)) hit_cnt_d = hit_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // in_ready is gated by reset so it reads 0 while reset is held low.
  assign bus.in_ready  = reset & (state_q == IDLE);
  assign bus.out_valid = (state_q == RESULT);
  assign bus.out_code  = code_q;
  assign bus.out_hit   = hit_q;
  assign bus.out_bank  = res_bank_q;
  assign busy          = (state_q != IDLE);
  assign stat_hits     = hit_cnt_q;
  assign state_dbg     = state_q;

endmodule

// File: doc/kw_scan_ctrl.md
Name: kw_scan_ctrl

Overview:
- Keyword-scan controller for the speech front end's symbol-matching path.
- Holds NBANK programmable 64-bit keyword banks; each bank packs 8 byte-wide keyword symbols.
- Accepts one 8-bit symbol at a time over a valid/ready handshake, then walks the banks one per cycle through a single shared 8-way byte comparator.
- Emits a registered result code plus the matching bank index, and keeps a saturating hit counter.

Parameters:
- NBANK, 4, number of keyword banks (power of 2, 2..16).
- BW, 2, bank index width; must equal log2(NBANK).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cfg_we  input  1  write cfg_data into bank cfg_addr and set that bank's valid bit.
- cfg_addr  input  BW  bank select for cfg_we.
- cfg_data  input  64  keyword bytes; byte k = bits [8k+7:8k].
- cfg_clr  input  1  clear all bank valid bits (bank contents retained).
- in_valid  input  1  symbol offered.
- in_ready  output  1  controller can accept a symbol.
- in_data  input  8  symbol.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_code  output  8  result code.
- out_hit  output  1  symbol matched a valid bank.
- out_bank  output  BW  first matching bank (0 when no hit).
- busy  output  1  state is not IDLE.
- stat_hits  output  16  count of hit results delivered; saturates at 16'hFFFF.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - Bank data, valid bits, symbol register and bank pointer clear to 0.
  - out_valid, out_code, out_hit, out_bank, busy and stat_hits read 0.
  - in_ready is 0 while reset is low, and 1 from the first cycle after release.
  - Reset mid-scan or mid-result discards the transaction with no output.
- FSM states: IDLE, SCAN, RESULT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: latch in_data, set ptr=0, go to SCAN.
- SCAN:
  - in_ready=0.
  - Each cycle compares the latched symbol against all 8 bytes of bank[ptr].
  - Hit requires valid[ptr]=1 and any byte equal; invalid banks are never hits and still cost one cycle.
  - On hit: register out_hit=1, out_bank=ptr, out_code=127; go to RESULT.
  - On miss with ptr==NBANK-1: register out_hit=0, out_bank=0, go to RESULT. out_code is 63 if the symbol is 7, 191 if it is 9, else 0.
  - Otherwise: ptr+1, stay in SCAN.
  - A hit takes priority over the 7/9 special codes.
- RESULT:
  - out_valid=1; out_code, out_hit and out_bank held stable until out_valid&out_ready.
  - At that edge: go to IDLE, out_valid falls, and stat_hits increments if out_hit=1 (no increment at 16'hFFFF).
  - Output registers keep their last values in IDLE; only out_valid qualifies them.
  - in_ready=0 in this state; there is no result/accept overlap, so throughput is at most one symbol per (scan cycles + 2) cycles.
- Latency, counted from the acceptance edge to the edge raising out_valid:
  - b+1 edges for a first hit in bank b.
  - NBANK edges for a miss.
- Config:
  - Writes take effect at the edge and are legal in any state.
  - A SCAN cycle comparing bank b while bank b is being written uses the pre-write value.
  - If cfg_clr and cfg_we occur together, all valid bits clear except cfg_addr's, which is written and set.
- busy = (state != IDLE).

Test Plan:
- Reset release, then symbol 8'h41 with no banks valid: out_valid after 4 edges; code 0, hit 0, bank 0; stat_hits 0.
- Bank 2 written with 64'h0000_0000_0000_4100, symbol 8'h41: out_valid 3 edges after acceptance; code 127, hit 1, bank 2; stat_hits becomes 1 on the out_ready edge.
- No valid banks, symbols 7 then 9 then 8: codes 63, 191, 0 respectively. Then bank 0 loaded with byte 7 and symbol 7 sent: code 127, bank 0 (hit priority).
- Symbol present in banks 1 and 3: bank 1 reported, latency 2. Hold out_ready=0 for 5 cycles: outputs stable and in_ready=0 throughout; new in_valid is not accepted.
- cfg_clr and cfg_we to bank 0 in the same cycle, with banks 0–3 holding the symbol: only bank 0 is valid; a subsequent scan hits bank 0. Then cfg_clr alone followed by the same symbol gives a miss.
- Assert reset mid-SCAN (ptr=2): all outputs 0 immediately and no out_valid. After release, a new symbol is processed normally. Also force stat_hits to 16'hFFFF by preload or a long run: a further hit leaves it at 16'hFFFF.
